// File: rtl/fifo_pkg.sv
// fifo_pkg: shared data width and transmitter state encoding for the FIFO UART path.
package fifo_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// bit_timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count; restart holds it at zero.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);
  localparam logic [15:0] TC = 16'(CLKS_PER_BIT - 1);
  logic [15:0] r_cnt;
  assign o_tick = !i_restart && (r_cnt == TC);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else r_cnt <= (i_restart || o_tick) ? '0 : r_cnt + 16'd1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the upstream FIFO and sends them LSB-first as async frames.
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_enable,
  input  logic              buf_empty,
  input  logic [DATA_W-1:0] buf_out,
  output logic              rd_en,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              byte_done,
  output logic [CNT_W-1:0]  frame_cnt
);
  tx_state_t         r_state;
  logic [DATA_W-1:0] r_shift;
  logic [2:0]        r_idx;
  logic              r_par, r_tx, w_tick, w_restart, w_go;
  assign w_go      = tx_enable && !buf_empty;
  assign w_restart = (r_state == IDLE) || (r_state == FETCH) || (r_state == LOAD);
  assign rd_en     = r_state == FETCH;
  assign tx_busy   = r_state != IDLE;
  assign byte_done = (r_state == STOP) && w_tick;
  assign tx_serial = r_tx;
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );
  // r_tx is loaded with the value of the state being entered, so the line is registered
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_idx     <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      frame_cnt <= '0;
    end else
      case (r_state)
        IDLE:  if (w_go) r_state <= FETCH;
        FETCH: r_state <= LOAD;
        LOAD: begin
          r_shift <= buf_out;
          r_par   <= ^buf_out;
          r_tx    <= 1'b0;
          r_state <= START;
        end
        START: if (w_tick) begin
          r_tx    <= r_shift[0];
          r_idx   <= '0;
          r_state <= DATA;
        end
        DATA: if (w_tick) begin
          if (r_idx == 3'd7) begin
            r_tx    <= (PARITY_EN != 0) ? r_par : 1'b1;
            r_state <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            r_shift <= r_shift >> 1;
            r_tx    <= r_shift[1];
            r_idx   <= r_idx + 3'd1;
          end
        end
        PARITY: if (w_tick) begin
          r_tx    <= 1'b1;
          r_state <= STOP;
        end
        STOP: if (w_tick) begin
          frame_cnt <= frame_cnt + CNT_W'(1);
          r_state   <= w_go ? FETCH : IDLE;
        end
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two transmitters (no parity / parity with 4-bit counter) fed from modelled FIFOs.
module tb_fifo_uart_tx;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, push_v = 1'b0;
  logic [7:0] push_d = 8'h00;
  logic rd[2], tx[2], busy[2], done[2], be[2];
  logic [7:0] bo[2];
  logic [15:0] fc0;
  logic [3:0] fc1;
  logic [7:0] q[2][$];
  logic [7:0] sent[$];
  logic [11:0] frames[2][$];
  logic [63:0] hist[2];
  int n_chk = 0, n_pass = 0, rdn[2] = '{0, 0}, mi[2] = '{0, 0}, mcnt[2] = '{0, 0};
  typedef struct packed {logic rd, tx, busy, done;} exp_t;
  exp_t eq[2][$];
  exp_t e;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .tx_enable(en), .buf_empty(be[0]), .buf_out(bo[0]), .rd_en(rd[0]),
    .tx_serial(tx[0]), .tx_busy(busy[0]), .byte_done(done[0]), .frame_cnt(fc0));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .tx_enable(en), .buf_empty(be[1]), .buf_out(bo[1]), .rd_en(rd[1]),
    .tx_serial(tx[1]), .tx_busy(busy[1]), .byte_done(done[1]), .frame_cnt(fc1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic r, input logic t, input logic b, input logic d);
    mk.rd = r; mk.tx = t; mk.busy = b; mk.done = d;
  endfunction

  // FIFO stub: read data appears the cycle after rd_en is sampled
  always @(posedge clk)
    for (int g = 0; g < 2; g++) begin
      if (rd[g] === 1'b1 && q[g].size() > 0) begin
        bo[g] <= q[g][0];
        void'(q[g].pop_front());
      end
      if (push_v) begin
        q[g].push_back(push_d);
        if (g == 0) sent.push_back(push_d);
      end
      be[g] <= (q[g].size() == 0);
    end

  // Reference: each frame is a list of per-cycle expected outputs, scheduled when idle
  always @(negedge clk)
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        chk($sformatf("rst_u%0d", g), {tx[g], rd[g], busy[g], done[g]}, 4'b1000);
        chk($sformatf("rst_cnt_u%0d", g), g ? 32'(fc1) : 32'(fc0), 0);
        eq[g].delete();
        mcnt[g] = 0;
      end else begin
        e = eq[g].size() > 0 ? eq[g].pop_front() : mk(0, 1, 0, 0);
        chk($sformatf("u%0d.rd_en", g), 32'(rd[g]), 32'(e.rd));
        chk($sformatf("u%0d.tx_serial", g), 32'(tx[g]), 32'(e.tx));
        chk($sformatf("u%0d.tx_busy", g), 32'(busy[g]), 32'(e.busy));
        chk($sformatf("u%0d.byte_done", g), 32'(done[g]), 32'(e.done));
        chk($sformatf("u%0d.frame_cnt", g), g ? 32'(fc1) : 32'(fc0), mcnt[g]);
        if (e.done) mcnt[g] = (mcnt[g] + 1) & (g ? 15 : 65535);
        if (eq[g].size() == 0 && en && mi[g] < sent.size()) begin
          logic [7:0] b;
          int nb;
          b = sent[mi[g]];
          mi[g]++;
          nb = g ? 11 : 10;
          eq[g].push_back(mk(1, 1, 1, 0));
          eq[g].push_back(mk(0, 1, 1, 0));
          for (int j = 0; j < nb; j++) begin
            logic v;
            v = (j == 0) ? 1'b0 : (j <= 8) ? b[j-1] : (j == 9 && g == 1) ? ^b : 1'b1;
            for (int c = 0; c < 4; c++) eq[g].push_back(mk(0, v, 1, (j == nb - 1) && (c == 3)));
          end
        end
      end
    end

  // Frame capture: bit j of a word is the line value in the second cycle of serial bit j
  always @(negedge clk)
    for (int g = 0; g < 2; g++) begin
      hist[g] = {hist[g][62:0], tx[g]};
      if (rd[g] === 1'b1) rdn[g]++;
      if (done[g] === 1'b1 && !rst) begin
        logic [11:0] w;
        int nb;
        nb = g ? 11 : 10;
        w = '0;
        for (int j = 0; j < nb; j++) w[j] = hist[g][4*nb-2-4*j];
        if (!(hist[g][4*nb] === 1'b1 && hist[g][4*nb-1] === 1'b0)) w = 12'hFFF;
        frames[g].push_back(w);
      end
    end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    push_d = b;
    push_v = 1'b1;
    cyc(1);
    push_v = 1'b0;
  endtask

  task automatic wait_done(input int n, input int lim);
    int k = 0;
    for (int i = 0; i < lim && k < n; i++) begin
      @(negedge clk);
      if (done[1] === 1'b1) k++;
    end
    chk("wait_done", k, n);
    cyc(1);
  endtask

  initial begin
    int k;
    cyc(1);
    push(8'hA5);
    en = 1'b1;
    cyc(3);
    chk("reset_tx", 32'(tx[0]), 1);
    chk("reset_rd", 32'(rd[0]), 0);
    chk("reset_busy", 32'(busy[0]), 0);
    chk("reset_cnt", 32'(fc0), 0);
    rst = 1'b0;
    wait_done(1, 200);
    chk("one_pop", rdn[0], 1);
    chk("cnt_after_1", 32'(fc0), 1);
    chk("frame_a5", 32'(frames[0][0]), 32'h34A);
    chk("frame_a5_par", 32'(frames[1][0]), 32'h54A);
    push(8'h07);
    wait_done(1, 200);
    chk("frame_07", 32'(frames[0][1]), 32'h20E);
    chk("frame_07_par", 32'(frames[1][1]), 32'h60E);
    push(8'h01);
    push(8'h80);
    push(8'hFF);
    wait_done(3, 600);
    chk("pops_b2b_u0", rdn[0], 5);
    chk("pops_b2b_u1", rdn[1], 5);
    chk("fifo_empty", q[0].size(), 0);
    chk("cnt_b2b", 32'(fc0), 5);
    chk("frame_80", 32'(frames[0][3]), 32'h300);
    chk("frame_ff_par", 32'(frames[1][4]), 32'h5FE);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    cyc(12);
    en = 1'b0;
    cyc(80);
    chk("held_fifo", q[0].size(), 2);
    chk("held_pops", rdn[0], 6);
    chk("held_cnt", 32'(fc0), 6);
    en = 1'b1;
    wait_done(2, 300);
    chk("resume_cnt", 32'(fc0), 8);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) == 0) push(8'($urandom));
      else cyc(1);
      if ($urandom_range(39) == 0) en = !en;
    end
    en = 1'b1;
    k = 0;
    while (k < 5000 && !(q[0].size() == 0 && q[1].size() == 0 && !busy[0] && !busy[1])) begin
      cyc(1);
      k++;
    end
    chk("drain", 32'(k < 5000), 1);
    cyc(2);
    push(8'h5A);
    push(8'h3C);
    k = 0;
    while (k < 50 && rd[0] !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    chk("fetch_seen", 32'(k < 50), 1);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_tx_u0", 32'(tx[0]), 1);
    chk("abort_tx_u1", 32'(tx[1]), 1);
    chk("abort_busy", 32'(busy[0]), 0);
    cyc(2);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) push(8'($urandom));
    wait_done(17, 2000);
    chk("cnt17_u0", 32'(fc0), 17);
    chk("cnt17_wrap_u1", 32'(fc1), 1);
    chk("final_empty", q[0].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
